// File: rtl/clk_sw_pkg.sv
// Shared types and helpers for the N-way clock-select sequencer.
// Holds the FSM state encoding, the dwell counter width and a one-hot helper.
package clk_sw_pkg;

  // Dwell counter width; OFF_CYC/ON_CYC must fit in it.
  localparam int CNT_W     = 8;

  // Upper bound on selectable sources and the index width that covers it.
  localparam int MAX_CLK   = 16;
  localparam int CLK_IDX_W = 4;

  // Sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OFF  = 2'd1,
    ON   = 2'd2,
    DONE = 2'd3
  } sw_state_e;

  // One-hot vector with bit idx set. Callers truncate to NUM_CLK bits.
  function automatic logic [MAX_CLK-1:0] onehot(input logic [CLK_IDX_W-1:0] idx);
    logic [MAX_CLK-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/clk_sw_seq_if.sv
// Request/response and gate-enable bundle of the clock-select sequencer.
// The lock_i input exists only when CLK_SW_LOCK_EN is defined.
interface clk_sw_seq_if #(
  parameter int NUM_CLK = 4,
  parameter int SEL_W   = 2
) ();

  logic               req_i;
  logic [SEL_W-1:0]   sel_i;
`ifdef CLK_SW_LOCK_EN
  logic               lock_i;
`endif
  logic               ack_o;
  logic               err_o;
  logic               busy_o;
  logic [NUM_CLK-1:0] gate_en_o;
  logic [SEL_W-1:0]   cur_sel_o;

`ifdef CLK_SW_LOCK_EN
  // Register-file side: issues requests, observes status.
  modport master (
    output req_i, sel_i, lock_i,
    input  ack_o, err_o, busy_o, gate_en_o, cur_sel_o
  );

  // Sequencer side.
  modport slave (
    input  req_i, sel_i, lock_i,
    output ack_o, err_o, busy_o, gate_en_o, cur_sel_o
  );
`else
  // Register-file side: issues requests, observes status.
  modport master (
    output req_i, sel_i,
    input  ack_o, err_o, busy_o, gate_en_o, cur_sel_o
  );

  // Sequencer side.
  modport slave (
    input  req_i, sel_i,
    output ack_o, err_o, busy_o, gate_en_o, cur_sel_o
  );
`endif

endinterface

// File: rtl/clk_sw_dly_cnt.sv
// Loadable 8-bit down-counter used to time both the all-off dwell and the
// post-enable settle phase. Load wins over decrement; the count stops at zero
// so an idle counter never wraps.
module clk_sw_dly_cnt
  import clk_sw_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] cnt_reg;

  // Reload on phase entry, otherwise count down while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  // Last cycle of the phase is the one where the count reads 1.
  assign done = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/clk_sw_seq.sv
// N-way glitch-free clock-select sequencer running on the always-on clock.
// Drives per-source ICG enables with break-before-make: the old gate closes,
// all gates stay low for OFF_CYC cycles, the new gate opens, and ack follows
// ON_CYC cycles later. Requests are only accepted while idle.
// Optional feature: define CLK_SW_LOCK_EN to add lock_i, which rejects every
// new request with err_o while high (it never aborts a switch in flight).
module clk_sw_seq
  import clk_sw_pkg::*;
#(
  parameter int NUM_CLK = 4,
  parameter int SEL_W   = 2,
  parameter int OFF_CYC = 4,
  parameter int ON_CYC  = 4,
  parameter int RST_SEL = 0
) (
  input  logic          clk,
  input  logic          rst,
  clk_sw_seq_if.slave   bus
);

  // Constant forms of the parameters at the widths they are compared/loaded at.
  localparam logic [SEL_W:0]     NUM_CLK_V = (SEL_W+1)'(NUM_CLK);
  localparam logic [SEL_W-1:0]   RST_IDX   = SEL_W'(RST_SEL);
  localparam logic [NUM_CLK-1:0] RST_GATE  = NUM_CLK'(onehot(CLK_IDX_W'(RST_SEL)));
  localparam logic [CNT_W-1:0]   OFF_LOAD  = CNT_W'(OFF_CYC);
  localparam logic [CNT_W-1:0]   ON_LOAD   = CNT_W'(ON_CYC);

  sw_state_e          state_reg,   state_next;
  logic [SEL_W-1:0]   target_reg,  target_next;
  logic [NUM_CLK-1:0] gate_en_reg, gate_en_next;
  logic [SEL_W-1:0]   cur_sel_reg, cur_sel_next;
  logic               ack_reg,     ack_next;
  logic               err_reg,     err_next;
  logic               busy_reg,    busy_next;

  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_en;
  logic               cnt_done;
  logic               lock_active;
  logic               sel_bad;

`ifdef CLK_SW_LOCK_EN
  assign lock_active = bus.lock_i;
`else
  assign lock_active = 1'b0;
`endif

  // Indices at or above NUM_CLK name no source and are rejected.
  assign sel_bad = ({1'b0, bus.sel_i} >= NUM_CLK_V);

  // One counter times both phases; it is reloaded on every state change.
  clk_sw_dly_cnt u_dly_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .done     (cnt_done)
  );

  // Next-state, gate and handshake decisions.
  always_comb begin
    state_next   = state_reg;
    target_next  = target_reg;
    gate_en_next = gate_en_reg;
    cur_sel_next = cur_sel_reg;
    ack_next     = 1'b0;
    err_next     = 1'b0;
    cnt_en       = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (bus.req_i) begin
          if (lock_active || sel_bad) begin
            err_next = 1'b1;
          end else if (bus.sel_i == cur_sel_reg) begin
            ack_next = 1'b1;
          end else begin
            target_next  = bus.sel_i;
            gate_en_next = '0;
            state_next   = OFF;
          end
        end
      end
      OFF: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          gate_en_next = NUM_CLK'(onehot(CLK_IDX_W'(target_reg)));
          cur_sel_next = target_reg;
          state_next   = ON;
        end
      end
      ON: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        ack_next   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
    cnt_load  = (state_next != state_reg);
    unique case (state_next)
      OFF:     cnt_val = OFF_LOAD;
      ON:      cnt_val = ON_LOAD;
      default: cnt_val = '0;
    endcase
  end

  // State and output flops; reset restores the RST_SEL source immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      target_reg  <= RST_IDX;
      gate_en_reg <= RST_GATE;
      cur_sel_reg <= RST_IDX;
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      target_reg  <= target_next;
      gate_en_reg <= gate_en_next;
      cur_sel_reg <= cur_sel_next;
      ack_reg     <= ack_next;
      err_reg     <= err_next;
      busy_reg    <= busy_next;
    end
  end

  // All outputs come straight from flops.
  assign bus.gate_en_o = gate_en_reg;
  assign bus.cur_sel_o = cur_sel_reg;
  assign bus.ack_o     = ack_reg;
  assign bus.err_o     = err_reg;
  assign bus.busy_o    = busy_reg;

endmodule

// File: tb/tb_clk_sw_seq.sv
// Scoreboard bench for clk_sw_seq: stimulus pushes expected ack/err responses,
// a monitor pops and compares them when the DUT responds. Two instances: a
// 4-source build with RST_SEL=0 and a 3-source build with RST_SEL=2.
module tb_clk_sw_seq;

  localparam int OFF_C = 4;
  localparam int ON_C  = 4;
  localparam int LAT   = OFF_C + ON_C + 2;

  localparam logic [1:0] K_ACK = 2'b01;
  localparam logic [1:0] K_ERR = 2'b10;

  typedef struct {
    logic [1:0] kind;
    int         cyc;
    logic [3:0] sel;
    logic [3:0] gate;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   zero_run = 0;
  exp_t q[$];
  exp_t q3[$];

  clk_sw_seq_if #(.NUM_CLK(4), .SEL_W(2)) bus ();
  clk_sw_seq_if #(.NUM_CLK(3), .SEL_W(2)) bus3 ();

  clk_sw_seq #(.NUM_CLK(4), .SEL_W(2), .OFF_CYC(OFF_C), .ON_CYC(ON_C), .RST_SEL(0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  clk_sw_seq #(.NUM_CLK(3), .SEL_W(2), .OFF_CYC(OFF_C), .ON_CYC(ON_C), .RST_SEL(2)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask

  task automatic issue(input logic [1:0] s, input int lat, input logic [1:0] kind,
                       input logic [3:0] esel, input logic [3:0] egate);
    exp_t e;
    @(posedge clk); #1;
    bus.req_i = 1'b1;
    bus.sel_i = s;
    e.kind = kind; e.cyc = cyc + lat; e.sel = esel; e.gate = egate;
    q.push_back(e);
    @(posedge clk); #1;
    bus.req_i = 1'b0;
  endtask

  task automatic issue3(input logic [1:0] s, input int lat, input logic [1:0] kind,
                        input logic [3:0] esel, input logic [3:0] egate);
    exp_t e;
    @(posedge clk); #1;
    bus3.req_i = 1'b1;
    bus3.sel_i = s;
    e.kind = kind; e.cyc = cyc + lat; e.sel = esel; e.gate = egate;
    q3.push_back(e);
    @(posedge clk); #1;
    bus3.req_i = 1'b0;
  endtask

  // Response monitor for the 4-source instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (bus.ack_o || bus.err_o)) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_resp: got ack=%0b err=%0b required no response at cycle %0d",
                   bus.ack_o, bus.err_o, cyc);
        end else begin
          e = q.pop_front();
          $display("[cyc %0d] dut resp ack=%0b err=%0b cur_sel=%0d gate=%b",
                   cyc, bus.ack_o, bus.err_o, bus.cur_sel_o, bus.gate_en_o);
          chk("resp_kind",    32'({bus.err_o, bus.ack_o}), 32'(e.kind));
          chk("resp_cycle",   cyc, e.cyc);
          chk("resp_cur_sel", 32'(bus.cur_sel_o), 32'(e.sel));
          chk("resp_gate",    32'(bus.gate_en_o), 32'(e.gate));
        end
      end
    end
  end

  // Response monitor for the 3-source instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (bus3.ack_o || bus3.err_o)) begin
        if (q3.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_resp3: got ack=%0b err=%0b required no response at cycle %0d",
                   bus3.ack_o, bus3.err_o, cyc);
        end else begin
          e = q3.pop_front();
          $display("[cyc %0d] dut3 resp ack=%0b err=%0b cur_sel=%0d gate=%b",
                   cyc, bus3.ack_o, bus3.err_o, bus3.cur_sel_o, bus3.gate_en_o);
          chk("resp3_kind",    32'({bus3.err_o, bus3.ack_o}), 32'(e.kind));
          chk("resp3_cycle",   cyc, e.cyc);
          chk("resp3_cur_sel", 32'(bus3.cur_sel_o), 32'(e.sel));
          chk("resp3_gate",    32'(bus3.gate_en_o), 32'(e.gate));
        end
      end
    end
  end

  // Gate monitor: never multi-hot, and every all-zero gap lasts exactly OFF_C cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        zero_run = 0;
      end else begin
        chk("gate_onehot0", 32'($onehot0(bus.gate_en_o)), 1);
        if (bus.gate_en_o == 4'b0000) begin
          zero_run++;
        end else begin
          if (zero_run != 0) chk("gate_off_dwell", zero_run, OFF_C);
          zero_run = 0;
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    bus.req_i  = 1'b0;
    bus.sel_i  = 2'd0;
    bus3.req_i = 1'b0;
    bus3.sel_i = 2'd0;
`ifdef CLK_SW_LOCK_EN
    bus.lock_i  = 1'b0;
    bus3.lock_i = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset values on both builds.
    chk("rst_gate",     32'(bus.gate_en_o), 32'h1);
    chk("rst_cur_sel",  32'(bus.cur_sel_o), 0);
    chk("rst_busy",     32'(bus.busy_o), 0);
    chk("rst_ack",      32'(bus.ack_o), 0);
    chk("rst_err",      32'(bus.err_o), 0);
    chk("rst3_gate",    32'(bus3.gate_en_o), 32'h4);
    chk("rst3_cur_sel", 32'(bus3.cur_sel_o), 2);
    chk("rst3_busy",    32'(bus3.busy_o), 0);

    // Real switch 0 -> 1: gates off for 4 cycles, then 0010; ack after LAT cycles.
    issue(2'd1, LAT, K_ACK, 4'd1, 4'b0010);
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("sw1_gate_k%0d", k), 32'(bus.gate_en_o), (k <= OFF_C) ? 0 : 32'h2);
      if (k == 1) chk("sw1_busy_start", 32'(bus.busy_o), 1);
      if (k == 9) chk("sw1_busy_last",  32'(bus.busy_o), 1);
      if (k == 10) chk("sw1_busy_drop", 32'(bus.busy_o), 0);
      if (k < 10) begin
        @(posedge clk); #1;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    chk("sw1_cur_sel", 32'(bus.cur_sel_o), 1);

    // Same-select request: immediate ack, gates stay put.
    issue(2'd1, 1, K_ACK, 4'd1, 4'b0010);
    chk("same_busy", 32'(bus.busy_o), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("same_gate", 32'(bus.gate_en_o), 32'h2);

    // Out-of-range select on the 3-source build: one err, gates unchanged.
    issue3(2'd3, 1, K_ERR, 4'd2, 4'b0100);
    repeat (3) @(posedge clk);
    #1;
    chk("bad3_gate", 32'(bus3.gate_en_o), 32'h4);
    chk("bad3_busy", 32'(bus3.busy_o), 0);

    // Second request during OFF is ignored; first target wins with one ack.
    issue(2'd2, LAT, K_ACK, 4'd2, 4'b0100);
    @(posedge clk); #1;
    bus.req_i = 1'b1;
    bus.sel_i = 2'd3;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("ovl_cur_sel", 32'(bus.cur_sel_o), 2);
    chk("ovl_gate",    32'(bus.gate_en_o), 32'h4);

    // Reset during the ON phase of a switch to 3 returns to source 0 at once.
    issue(2'd3, LAT, K_ACK, 4'd3, 4'b1000);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_on_gate", 32'(bus.gate_en_o), 32'h8);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_gate",    32'(bus.gate_en_o), 32'h1);
    chk("arst_cur_sel", 32'(bus.cur_sel_o), 0);
    chk("arst_busy",    32'(bus.busy_o), 0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_gate", 32'(bus.gate_en_o), 32'h1);

`ifdef CLK_SW_LOCK_EN
    // Lock rejects both a real switch and a same-select request.
    bus.lock_i = 1'b1;
    issue(2'd2, 1, K_ERR, 4'd0, 4'b0001);
    issue(2'd0, 1, K_ERR, 4'd0, 4'b0001);
    repeat (3) @(posedge clk);
    #1;
    chk("lock_gate", 32'(bus.gate_en_o), 32'h1);
    bus.lock_i = 1'b0;
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty",  q.size(), 0);
    chk("queue3_empty", q3.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
